// File: rtl/cv32e40p_x_if_pkg.sv
// ============================================================================
// Module      : cv32e40p_x_if_pkg
// Description : Shared types for the cv32e40p X-interface dispatcher.
//               x_disp_idx_t : coprocessor index as held in the outstanding
//                              queue (sized for the default coprocessor count)
//               x_result_t   : one result beat {rd, data, error}
//               x_disp_idx_w : index width for a given coprocessor count,
//                              max(1, clog2(n))
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cv32e40p_x_if_pkg;

  localparam int unsigned X_DISP_NUM_COPROC = 2;

  // A single coprocessor still needs a 1-bit index so the queue has a width.
  function automatic int unsigned x_disp_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned X_DISP_IDX_W = x_disp_idx_w(X_DISP_NUM_COPROC);

  typedef logic [X_DISP_IDX_W-1:0] x_disp_idx_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        error;
  } x_result_t;

endpackage

`default_nettype wire

// File: rtl/cv32e40p_fifo.sv
// ============================================================================
// Module      : cv32e40p_fifo
// Description : Synchronous FIFO with an occupancy counter of
//               clog2(DEPTH)+1 bits. A push while full and a pop while empty
//               are ignored. Pointers wrap modulo DEPTH.
// Ports       : clk_i, rst_ni (synchronous, active low)
//               push_i / data_i      write side
//               pop_i  / data_o      read side (data_o shows the head)
//               empty_o / full_o     status
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int unsigned C_PTR_W = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
  localparam int unsigned C_CNT_W = $clog2(DEPTH) + 1;
  localparam logic [C_PTR_W-1:0] C_PTR_LAST = C_PTR_W'(DEPTH - 1);
  localparam logic [C_CNT_W-1:0] C_CNT_FULL = C_CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [C_PTR_W-1:0]    r_wr_ptr;
  logic [C_PTR_W-1:0]    r_rd_ptr;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign empty_o = (r_cnt == '0);
  assign full_o  = (r_cnt == C_CNT_FULL);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin : p_ctrl
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + C_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + C_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + C_CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - C_CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage carries no reset: an entry is only read after it was written.
  always_ff @(posedge clk_i) begin : p_mem
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cv32e40p_x_dispatcher.sv
// ============================================================================
// Module      : cv32e40p_x_dispatcher
// Description : X-interface dispatcher between the cv32e40p core and
//               NUM_COPROC coprocessors. Every offload is broadcast to all
//               coprocessors; the lowest-index acceptor wins. Writeback
//               instructions log the winner index in an in-order queue and
//               results go back to the core strictly in issue order.
// Ports       : core side   x_valid_i/x_ready_o, x_instr_data_i, x_rs_i,
//                           x_rs_valid_i, x_accept_o, x_writeback_o,
//                           x_is_mem_op_o, x_rvalid_o/x_rready_i, x_rd_o,
//                           x_data_o, x_error_o
//               coproc side x_cp_* (one bit/lane per coprocessor, request
//                           payload broadcast)
//               status      multi_accept_o (sticky until reset)
// Option      : CV32E40P_X_DISP_TIMEOUT_EN enables a head-of-queue timeout
//               producing a synthetic error response and drain counters that
//               swallow late results. Undefined: the head waits forever.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cv32e40p_x_dispatcher
  import cv32e40p_x_if_pkg::*;
#(
  parameter int unsigned NUM_COPROC     = 2,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        x_valid_i,
  output logic                        x_ready_o,
  input  logic [31:0]                 x_instr_data_i,
  input  logic [2:0][31:0]            x_rs_i,
  input  logic [2:0]                  x_rs_valid_i,
  output logic                        x_accept_o,
  output logic                        x_writeback_o,
  output logic                        x_is_mem_op_o,
  output logic                        x_rvalid_o,
  input  logic                        x_rready_i,
  output logic [4:0]                  x_rd_o,
  output logic [31:0]                 x_data_o,
  output logic                        x_error_o,
  output logic [NUM_COPROC-1:0]       x_cp_valid_o,
  input  logic [NUM_COPROC-1:0]       x_cp_ready_i,
  output logic [31:0]                 x_cp_instr_data_o,
  output logic [2:0][31:0]            x_cp_rs_o,
  output logic [2:0]                  x_cp_rs_valid_o,
  input  logic [NUM_COPROC-1:0]       x_cp_accept_i,
  input  logic [NUM_COPROC-1:0]       x_cp_writeback_i,
  input  logic [NUM_COPROC-1:0]       x_cp_is_mem_op_i,
  input  logic [NUM_COPROC-1:0]       x_cp_rvalid_i,
  output logic [NUM_COPROC-1:0]       x_cp_rready_o,
  input  logic [NUM_COPROC-1:0][4:0]  x_cp_rd_i,
  input  logic [NUM_COPROC-1:0][31:0] x_cp_data_i,
  input  logic [NUM_COPROC-1:0]       x_cp_error_i,
  output logic                        multi_accept_o
);

  localparam int unsigned C_IDX_W = x_disp_idx_w(NUM_COPROC);

  logic               w_full;
  logic               w_empty;
  logic               w_hs;
  logic               w_push;
  logic               w_pop;
  logic               w_multi;
  logic [C_IDX_W-1:0] w_winner;
  logic [C_IDX_W-1:0] w_head;
  logic               w_win_wb;
  logic               w_win_mem;
  logic               w_head_rvalid;
  x_result_t          w_head_res;
  x_result_t          w_res;
  logic               r_multi_accept;

  // Degenerate configurations leave an empty, clearly named scope behind.
  if (NUM_COPROC < 1 || DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
  end

  // ---------------------------------------------------------------- request
  assign x_cp_instr_data_o = x_instr_data_i;
  assign x_cp_rs_o         = x_rs_i;
  assign x_cp_rs_valid_o   = x_rs_valid_i;

  // Full blocks new requests even when the head pops in the same cycle, so
  // the ready path never depends on the response path.
  assign x_cp_valid_o = {NUM_COPROC{x_valid_i & ~w_full}};
  assign x_ready_o    = ~w_full & (&x_cp_ready_i);
  assign w_hs         = x_valid_i & x_ready_o;

  // Descending scan so the lowest accepting index is the one left standing.
  always_comb begin : p_accept_prio
    w_winner  = '0;
    w_win_wb  = 1'b0;
    w_win_mem = 1'b0;
    for (int i = NUM_COPROC - 1; i >= 0; i--) begin
      if (x_cp_accept_i[i]) begin
        w_winner  = C_IDX_W'(i);
        w_win_wb  = x_cp_writeback_i[i];
        w_win_mem = x_cp_is_mem_op_i[i];
      end
    end
  end

  assign x_accept_o    = |x_cp_accept_i;
  assign x_writeback_o = w_win_wb;
  assign x_is_mem_op_o = w_win_mem;

  // x & (x-1) clears the lowest set bit; anything left means a second acceptor.
  assign w_multi = |(x_cp_accept_i & (x_cp_accept_i - NUM_COPROC'(1)));
  assign w_push  = w_hs & x_accept_o & w_win_wb;

  always_ff @(posedge clk_i) begin : p_multi
    if (!rst_ni) begin
      r_multi_accept <= 1'b0;
    end else if (w_hs && w_multi) begin
      r_multi_accept <= 1'b1;
    end
  end

  assign multi_accept_o = r_multi_accept;

  // ----------------------------------------------------------- issue order
  cv32e40p_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (C_IDX_W)
  ) u_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_winner),
    .data_o  (w_head),
    .empty_o (w_empty),
    .full_o  (w_full)
  );

  // --------------------------------------------------------------- response
  always_comb begin : p_head_mux
    w_head_rvalid = 1'b0;
    w_head_res    = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (w_head == C_IDX_W'(i)) begin
        w_head_rvalid = x_cp_rvalid_i[i];
        w_head_res    = '{rd: x_cp_rd_i[i], data: x_cp_data_i[i], error: x_cp_error_i[i]};
      end
    end
  end

`ifdef CV32E40P_X_DISP_TIMEOUT_EN
  localparam int unsigned        C_TMR_W   = (TIMEOUT_CYCLES <= 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam int unsigned        C_DRN_W   = $clog2(DEPTH) + 1;
  localparam logic [C_TMR_W-1:0] C_TMR_MAX = C_TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [C_DRN_W-1:0] C_DRN_MAX = C_DRN_W'(DEPTH);

  logic [C_TMR_W-1:0]                  r_timer;
  logic [NUM_COPROC-1:0][C_DRN_W-1:0]  r_drain;
  logic [C_DRN_W-1:0]                  w_head_drain;
  logic [NUM_COPROC-1:0]               w_drain_inc;
  logic [NUM_COPROC-1:0]               w_drain_dec;
  logic                                w_fwd;
  logic                                w_real_rsp;
  logic                                w_timeout;

  always_comb begin : p_head_drain
    w_head_drain = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (w_head == C_IDX_W'(i)) begin
        w_head_drain = r_drain[i];
      end
    end
  end

  // A head whose coprocessor still owes abandoned results is never forwarded:
  // the next beat from it belongs to an earlier, already timed-out request.
  assign w_fwd      = ~w_empty & (w_head_drain == '0);
  assign w_real_rsp = w_fwd & w_head_rvalid;
  assign w_timeout  = ~w_empty & ~w_real_rsp & (r_timer == C_TMR_MAX);
  assign x_rvalid_o = w_real_rsp | w_timeout;
  assign w_pop      = x_rvalid_o & x_rready_i;

  always_comb begin : p_rsp
    w_res         = '0;
    x_cp_rready_o = '0;
    if (w_timeout) begin
      w_res = '{rd: 5'd0, data: 32'd0, error: 1'b1};
    end else if (w_fwd) begin
      w_res = w_head_res;
    end
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (r_drain[i] != '0) begin
        x_cp_rready_o[i] = 1'b1;
      end else if (w_fwd && (w_head == C_IDX_W'(i))) begin
        x_cp_rready_o[i] = x_rready_i;
      end
    end
  end

  always_comb begin : p_drain_ctl
    w_drain_inc = '0;
    w_drain_dec = '0;
    for (int i = 0; i < NUM_COPROC; i++) begin
      w_drain_inc[i] = w_timeout & x_rready_i & (w_head == C_IDX_W'(i));
      w_drain_dec[i] = (r_drain[i] != '0) & x_cp_rvalid_i[i];
    end
  end

  always_ff @(posedge clk_i) begin : p_timer
    if (!rst_ni) begin
      r_timer <= '0;
    end else if (w_empty || w_pop) begin
      r_timer <= '0;
    end else if (r_timer != C_TMR_MAX) begin
      r_timer <= r_timer + C_TMR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin : p_drain
    if (!rst_ni) begin
      r_drain <= '0;
    end else begin
      for (int i = 0; i < NUM_COPROC; i++) begin
        case ({w_drain_inc[i], w_drain_dec[i]})
          2'b10: begin
            if (r_drain[i] != C_DRN_MAX) begin
              r_drain[i] <= r_drain[i] + C_DRN_W'(1);
            end
          end
          2'b01:   r_drain[i] <= r_drain[i] - C_DRN_W'(1);
          default: r_drain[i] <= r_drain[i];
        endcase
      end
    end
  end
`else
  assign x_rvalid_o = ~w_empty & w_head_rvalid;
  assign w_pop      = x_rvalid_o & x_rready_i;

  // Only the head coprocessor sees rready; all others stall until their turn.
  always_comb begin : p_rsp
    w_res         = '0;
    x_cp_rready_o = '0;
    if (!w_empty) begin
      w_res = w_head_res;
    end
    for (int i = 0; i < NUM_COPROC; i++) begin
      if (!w_empty && (w_head == C_IDX_W'(i))) begin
        x_cp_rready_o[i] = x_rready_i;
      end
    end
  end
`endif

  assign x_rd_o    = w_res.rd;
  assign x_data_o  = w_res.data;
  assign x_error_o = w_res.error;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_x_dispatcher.sv
// ============================================================================
// Module      : tb_cv32e40p_x_dispatcher
// Description : Self-checking bench for cv32e40p_x_dispatcher (N=2, DEPTH=4,
//               TIMEOUT_CYCLES=8). Request/accept paths come from a vector
//               table; results are checked in issue order against a queue of
//               expected beats. Timeout checks are built only when
//               CV32E40P_X_DISP_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cv32e40p_x_dispatcher;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              x_valid_i;
  logic              x_ready_o;
  logic [31:0]       x_instr_data_i;
  logic [2:0][31:0]  x_rs_i;
  logic [2:0]        x_rs_valid_i;
  logic              x_accept_o;
  logic              x_writeback_o;
  logic              x_is_mem_op_o;
  logic              x_rvalid_o;
  logic              x_rready_i;
  logic [4:0]        x_rd_o;
  logic [31:0]       x_data_o;
  logic              x_error_o;
  logic [N-1:0]      x_cp_valid_o;
  logic [N-1:0]      x_cp_ready_i;
  logic [31:0]       x_cp_instr_data_o;
  logic [2:0][31:0]  x_cp_rs_o;
  logic [2:0]        x_cp_rs_valid_o;
  logic [N-1:0]      x_cp_accept_i;
  logic [N-1:0]      x_cp_writeback_i;
  logic [N-1:0]      x_cp_is_mem_op_i;
  logic [N-1:0]      x_cp_rvalid_i;
  logic [N-1:0]      x_cp_rready_o;
  logic [N-1:0][4:0] x_cp_rd_i;
  logic [N-1:0][31:0] x_cp_data_i;
  logic [N-1:0]      x_cp_error_i;
  logic              multi_accept_o;

  always #5 clk = ~clk;

  cv32e40p_x_dispatcher #(
    .NUM_COPROC     (N),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .x_valid_i         (x_valid_i),
    .x_ready_o         (x_ready_o),
    .x_instr_data_i    (x_instr_data_i),
    .x_rs_i            (x_rs_i),
    .x_rs_valid_i      (x_rs_valid_i),
    .x_accept_o        (x_accept_o),
    .x_writeback_o     (x_writeback_o),
    .x_is_mem_op_o     (x_is_mem_op_o),
    .x_rvalid_o        (x_rvalid_o),
    .x_rready_i        (x_rready_i),
    .x_rd_o            (x_rd_o),
    .x_data_o          (x_data_o),
    .x_error_o         (x_error_o),
    .x_cp_valid_o      (x_cp_valid_o),
    .x_cp_ready_i      (x_cp_ready_i),
    .x_cp_instr_data_o (x_cp_instr_data_o),
    .x_cp_rs_o         (x_cp_rs_o),
    .x_cp_rs_valid_o   (x_cp_rs_valid_o),
    .x_cp_accept_i     (x_cp_accept_i),
    .x_cp_writeback_i  (x_cp_writeback_i),
    .x_cp_is_mem_op_i  (x_cp_is_mem_op_i),
    .x_cp_rvalid_i     (x_cp_rvalid_i),
    .x_cp_rready_o     (x_cp_rready_o),
    .x_cp_rd_i         (x_cp_rd_i),
    .x_cp_data_i       (x_cp_data_i),
    .x_cp_error_i      (x_cp_error_i),
    .multi_accept_o    (multi_accept_o)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } res_t;

  // Request-path vector: inputs and expected {x_ready, cp_valid[1:0],
  // accept, writeback, is_mem_op, rvalid}.
  typedef struct {
    string      name;
    logic       valid;
    logic [1:0] rdy;
    logic [1:0] acc;
    logic [1:0] wb;
    logic [1:0] mem;
    logic [6:0] exp;
  } vec_t;

  res_t sb[$];
  res_t cp_q[N][$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction until the handshake completes; on a writeback
  // accept, the planned result joins the winner's queue and the scoreboard.
  task automatic issue(input logic [31:0] instr, input logic [1:0] acc, input logic [1:0] wb,
                       input logic [1:0] mem, input res_t r);
    int cyc;
    int w;
    cyc              = 0;
    x_valid_i        = 1'b1;
    x_instr_data_i   = instr;
    x_cp_ready_i     = 2'b11;
    x_cp_accept_i    = acc;
    x_cp_writeback_i = wb;
    x_cp_is_mem_op_i = mem;
    #3;
    while (!x_ready_o && cyc < 20) begin
      tick();
      #3;
      cyc++;
    end
    check("instr_bcast", 64'(x_cp_instr_data_o), 64'(instr));
    if (!x_ready_o) begin
      check("issue_ready_timeout", 64'(x_ready_o), 64'd1);
    end else begin
      w = acc[0] ? 0 : 1;
      if (acc != 2'b00 && wb[w]) begin
        cp_q[w].push_back(r);
        sb.push_back(r);
      end
    end
    tick();
    x_valid_i        = 1'b0;
    x_cp_accept_i    = '0;
    x_cp_writeback_i = '0;
    x_cp_is_mem_op_i = '0;
  endtask

  // Let the enabled coprocessors answer from their queues; every result the
  // core takes is compared against the oldest scoreboard entry.
  task automatic drain(input logic [N-1:0] en, input int budget);
    int cyc;
    res_t e;
    cyc = 0;
    while (sb.size() > 0 && cyc < budget) begin
      for (int i = 0; i < N; i++) begin
        if (en[i] && cp_q[i].size() > 0) begin
          x_cp_rvalid_i[i] = 1'b1;
          x_cp_rd_i[i]     = cp_q[i][0].rd;
          x_cp_data_i[i]   = cp_q[i][0].data;
          x_cp_error_i[i]  = cp_q[i][0].err;
        end else begin
          x_cp_rvalid_i[i] = 1'b0;
        end
      end
      #3;
      if (x_rvalid_o && x_rready_i) begin
        e = sb.pop_front();
        check("resp", 64'({x_rd_o, x_data_o, x_error_o}), 64'(e));
      end
      for (int i = 0; i < N; i++) begin
        if (x_cp_rvalid_i[i] && x_cp_rready_o[i]) begin
          void'(cp_q[i].pop_front());
        end
      end
      tick();
      cyc++;
    end
    x_cp_rvalid_i = '0;
    if (sb.size() > 0) begin
      check("drain_budget_left", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    res_t r;
    logic stall_ok;

    vecs[0] = '{"idle",          1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 7'b1_00_0_0_0_0};
    vecs[1] = '{"cp1_not_ready", 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 7'b0_11_0_0_0_0};
    vecs[2] = '{"nonwb_accept",  1'b1, 2'b11, 2'b10, 2'b00, 2'b10, 7'b1_11_1_0_1_0};
    vecs[3] = '{"rejected",      1'b1, 2'b11, 2'b00, 2'b11, 2'b11, 7'b1_11_0_0_0_0};
    vecs[4] = '{"accept_no_hs",  1'b0, 2'b11, 2'b01, 2'b01, 2'b00, 7'b1_00_1_1_0_0};
    vecs[5] = '{"prio_no_ready", 1'b1, 2'b10, 2'b11, 2'b10, 2'b01, 7'b0_11_1_0_1_0};

    rst_n            = 1'b0;
    x_valid_i        = 1'b0;
    x_instr_data_i   = '0;
    x_rs_i           = '{32'h11, 32'h22, 32'h33};
    x_rs_valid_i     = 3'b111;
    x_rready_i       = 1'b1;
    x_cp_ready_i     = '0;
    x_cp_accept_i    = '0;
    x_cp_writeback_i = '0;
    x_cp_is_mem_op_i = '0;
    x_cp_rvalid_i    = '0;
    x_cp_rd_i        = '0;
    x_cp_data_i      = '0;
    x_cp_error_i     = '0;

    // Reset state
    tick();
    tick();
    #3;
    check("rst_ready", 64'(x_ready_o), 64'd0);
    check("rst_rvalid", 64'(x_rvalid_o), 64'd0);
    check("rst_cp_valid", 64'(x_cp_valid_o), 64'd0);
    check("rst_cp_rready", 64'(x_cp_rready_o), 64'd0);
    check("rst_multi", 64'(multi_accept_o), 64'd0);
    check("rs_bcast", 64'(x_cp_rs_o[1]), 64'h22);
    rst_n = 1'b1;
    tick();

    // Request / accept path table
    for (int k = 0; k < 6; k++) begin
      x_valid_i        = vecs[k].valid;
      x_cp_ready_i     = vecs[k].rdy;
      x_cp_accept_i    = vecs[k].acc;
      x_cp_writeback_i = vecs[k].wb;
      x_cp_is_mem_op_i = vecs[k].mem;
      #3;
      check(vecs[k].name,
            64'({x_ready_o, x_cp_valid_o, x_accept_o, x_writeback_o, x_is_mem_op_o, x_rvalid_o}),
            64'(vecs[k].exp));
      tick();
    end
    x_valid_i        = 1'b0;
    x_cp_ready_i     = 2'b11;
    x_cp_accept_i    = '0;
    x_cp_writeback_i = '0;
    x_cp_is_mem_op_i = '0;
    #3;
    check("no_push_nonwb", 64'(x_cp_rready_o), 64'd0);
    check("no_multi_without_hs", 64'(multi_accept_o), 64'd0);
    tick();

    // Single writeback through cp1
    r = '{rd: 5'd5, data: 32'h0000_CAFE, err: 1'b0};
    issue(32'h0000_702B, 2'b10, 2'b10, 2'b00, r);
    drain(2'b10, 10);
    #3;
    check("empty_after_t1_rvalid", 64'(x_rvalid_o), 64'd0);
    check("empty_after_t1_rready", 64'(x_cp_rready_o), 64'd0);
    tick();

    // Out-of-order completion held back until the older result leaves
    r = '{rd: 5'd1, data: 32'hAAAA_0001, err: 1'b0};
    issue(32'h0000_100B, 2'b01, 2'b01, 2'b00, r);
    r = '{rd: 5'd2, data: 32'hBBBB_0002, err: 1'b1};
    issue(32'h0000_200B, 2'b10, 2'b10, 2'b00, r);
    x_cp_rvalid_i[1] = 1'b1;
    x_cp_rd_i[1]     = cp_q[1][0].rd;
    x_cp_data_i[1]   = cp_q[1][0].data;
    x_cp_error_i[1]  = cp_q[1][0].err;
    for (int k = 0; k < 3; k++) begin
      #3;
      check("hold_rready1", 64'(x_cp_rready_o[1]), 64'd0);
      check("hold_rvalid", 64'(x_rvalid_o), 64'd0);
      tick();
    end
    drain(2'b11, 20);

    // Fill to DEPTH, then one pop re-opens the request path a cycle later
    for (int k = 0; k < 4; k++) begin
      r = '{rd: 5'(10 + k), data: 32'h3000_0000 + 32'(k), err: 1'b0};
      issue(32'h0000_300B + 32'(k), 2'b01, 2'b01, 2'b00, r);
    end
    x_valid_i    = 1'b1;
    x_cp_ready_i = 2'b11;
    #3;
    check("full_block", 64'({x_ready_o, x_cp_valid_o}), 64'd0);
    tick();
    x_cp_rvalid_i[0] = 1'b1;
    x_cp_rd_i[0]     = cp_q[0][0].rd;
    x_cp_data_i[0]   = cp_q[0][0].data;
    x_cp_error_i[0]  = cp_q[0][0].err;
    #3;
    check("full_during_pop", 64'({x_ready_o, x_cp_valid_o}), 64'd0);
    if (x_rvalid_o && x_rready_i) begin
      r = sb.pop_front();
      check("resp_full_pop", 64'({x_rd_o, x_data_o, x_error_o}), 64'(r));
      void'(cp_q[0].pop_front());
    end else begin
      check("full_pop_rvalid", 64'(x_rvalid_o), 64'd1);
    end
    tick();
    x_cp_rvalid_i = '0;
    #3;
    check("ready_after_pop", 64'({x_ready_o, x_cp_valid_o}), 64'b111);
    tick();
    x_valid_i = 1'b0;
    drain(2'b01, 20);

    // Double accept: cp0 wins and the sticky flag rises
    r = '{rd: 5'd7, data: 32'h0000_0044, err: 1'b0};
    issue(32'h0000_400B, 2'b11, 2'b11, 2'b00, r);
    #3;
    check("multi_set", 64'(multi_accept_o), 64'd1);
    tick();
    drain(2'b11, 10);
    #3;
    check("multi_sticky", 64'(multi_accept_o), 64'd1);
    tick();

    // Reset with two entries outstanding
    r = '{rd: 5'd8, data: 32'h5555_0008, err: 1'b0};
    issue(32'h0000_500B, 2'b10, 2'b10, 2'b00, r);
    issue(32'h0000_600B, 2'b10, 2'b10, 2'b00, r);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    cp_q[1].delete();
    x_cp_rvalid_i[1] = 1'b1;
    x_cp_rd_i[1]     = 5'd8;
    x_cp_data_i[1]   = 32'h5555_0008;
    #3;
    check("rst_mid_rvalid", 64'(x_rvalid_o), 64'd0);
    check("rst_mid_rready", 64'(x_cp_rready_o), 64'd0);
    check("rst_mid_multi", 64'(multi_accept_o), 64'd0);
    tick();
    x_cp_rvalid_i = '0;

    r = '{rd: 5'd9, data: 32'h9999_0009, err: 1'b1};
    issue(32'h0000_700B, 2'b10, 2'b10, 2'b10, r);
    drain(2'b10, 10);

`ifdef CV32E40P_X_DISP_TIMEOUT_EN
    // Silent cp0: synthetic error in the 8th stalled cycle, late beat dropped
    r = '{rd: 5'd3, data: 32'hDEAD_0003, err: 1'b0};
    issue(32'h0000_800B, 2'b01, 2'b01, 2'b00, r);
    void'(sb.pop_back());
    stall_ok = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      #3;
      if (x_rvalid_o) stall_ok = 1'b0;
      tick();
    end
    check("timeout_quiet_7", 64'(stall_ok), 64'd1);
    #3;
    check("timeout_rsp", 64'({x_rvalid_o, x_rd_o, x_data_o, x_error_o}),
          64'({1'b1, 5'd0, 32'd0, 1'b1}));
    tick();
    x_rready_i       = 1'b0;
    x_cp_rvalid_i[0] = 1'b1;
    x_cp_rd_i[0]     = cp_q[0][0].rd;
    x_cp_data_i[0]   = cp_q[0][0].data;
    x_cp_error_i[0]  = cp_q[0][0].err;
    #3;
    check("late_rready", 64'(x_cp_rready_o[0]), 64'd1);
    check("late_not_fwd", 64'(x_rvalid_o), 64'd0);
    void'(cp_q[0].pop_front());
    tick();
    x_cp_rvalid_i = '0;
    x_rready_i    = 1'b1;
    #3;
    check("drain_done", 64'(x_cp_rready_o), 64'd0);
    tick();
`else
    // Without the timeout the head waits as long as it takes
    r = '{rd: 5'd3, data: 32'hDEAD_0003, err: 1'b0};
    issue(32'h0000_800B, 2'b01, 2'b01, 2'b00, r);
    stall_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #3;
      if (x_rvalid_o) stall_ok = 1'b0;
      tick();
    end
    check("no_timeout_wait", 64'(stall_ok), 64'd1);
    #3;
    check("head_rready_waiting", 64'(x_cp_rready_o), 64'b01);
    tick();
    drain(2'b01, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
